// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and execute.
// The slave side is the queue itself; the master side is the surrounding pipeline.
interface decode_queue_if #(
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_next_pc;
  logic [31:0]   in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_next_pc;
  logic [31:0]   out_imm;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic [4:0]    out_rd;
  logic [11:0]   out_csr_addr;
  logic [2:0]    out_alu_fn;
  logic          out_alu_mod;
  logic [1:0]    out_sel_a;
  logic [1:0]    out_sel_b;
  logic [2:0]    out_funct3;
  logic [3:0]    out_class;
  logic          out_csr_rd;
  logic          out_csr_wr;
  logic          out_exception;
  logic [3:0]    out_ecause;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_pc, in_next_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_next_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_csr_addr, out_alu_fn, out_alu_mod, out_sel_a, out_sel_b, out_funct3,
           out_class, out_csr_rd, out_csr_wr, out_exception, out_ecause, count
  );

  modport master (
    output in_valid, in_pc, in_next_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_next_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_csr_addr, out_alu_fn, out_alu_mod, out_sel_a, out_sel_b, out_funct3,
           out_class, out_csr_rd, out_csr_wr, out_exception, out_ecause, count
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I(+M) decoder feeding a DEPTH-entry micro-op FIFO with valid/ready on both sides.
// Illegal encodings are enqueued as exception entries so fetch order is never broken.
module decode_queue #(
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b0
) (
  input logic           clk,
  input logic           reset_n,
  decode_queue_if.slave dq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CLS_ALU    = 4'd0;
  localparam logic [3:0] CLS_LOAD   = 4'd1;
  localparam logic [3:0] CLS_STORE  = 4'd2;
  localparam logic [3:0] CLS_BRANCH = 4'd3;
  localparam logic [3:0] CLS_JUMP   = 4'd4;
  localparam logic [3:0] CLS_CSR    = 4'd5;
  localparam logic [3:0] CLS_MRET   = 4'd6;
  localparam logic [3:0] CLS_WFI    = 4'd7;
  localparam logic [3:0] CLS_MULDIV = 4'd8;
  localparam logic [3:0] CLS_FENCE  = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_AND = 3'd7;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;
  localparam logic [1:0] SEL_CSR = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic [2:0]  alu_fn;
    logic        alu_mod;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [2:0]  funct3;
    logic [3:0]  cls;
    logic        csr_rd;
    logic        csr_wr;
    logic        exception;
    logic [3:0]  ecause;
  } uop_t;

  logic [31:0] ins_s;
  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic        illegal_s;
  uop_t        raw_s;
  uop_t        uop_s;

  assign ins_s   = dq.in_instr;
  assign opc_s   = ins_s[6:0];
  assign f3_s    = ins_s[14:12];
  assign f7_s    = ins_s[31:25];
  assign rd_s    = ins_s[11:7];
  assign rs1_s   = ins_s[19:15];
  assign imm_i_s = {{20{ins_s[31]}}, ins_s[31:20]};
  assign imm_s_s = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
  assign imm_b_s = {{19{ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
  assign imm_u_s = {ins_s[31:12], 12'h000};
  assign imm_j_s = {{11{ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};

  // Combinational decode of the offered instruction into a micro-op
  always_comb begin
    raw_s          = '0;
    raw_s.pc       = dq.in_pc;
    raw_s.next_pc  = dq.in_next_pc;
    raw_s.rs1      = rs1_s;
    raw_s.rs2      = ins_s[24:20];
    raw_s.csr_addr = ins_s[31:20];
    raw_s.funct3   = f3_s;
    illegal_s      = 1'b0;
    case (opc_s)
      OPC_LUI: begin
        raw_s.imm    = imm_u_s;
        raw_s.rd     = rd_s;
        raw_s.alu_fn = ALU_OR;
        raw_s.sel_a  = SEL_IMM;
        raw_s.sel_b  = SEL_IMM;
      end
      OPC_AUIPC: begin
        raw_s.imm   = imm_u_s;
        raw_s.rd    = rd_s;
        raw_s.sel_a = SEL_PC;
        raw_s.sel_b = SEL_IMM;
      end
      OPC_JAL: begin
        raw_s.imm   = imm_j_s;
        raw_s.rd    = rd_s;
        raw_s.cls   = CLS_JUMP;
        raw_s.sel_a = SEL_PC;
        raw_s.sel_b = SEL_IMM;
      end
      OPC_JALR: begin
        raw_s.imm   = imm_i_s;
        raw_s.rd    = rd_s;
        raw_s.cls   = CLS_JUMP;
        raw_s.sel_b = SEL_IMM;
        illegal_s   = (f3_s != 3'b000);
      end
      OPC_BRANCH: begin
        raw_s.imm     = imm_b_s;
        raw_s.cls     = CLS_BRANCH;
        raw_s.alu_mod = 1'b1;
        illegal_s     = (f3_s[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        raw_s.imm   = imm_i_s;
        raw_s.rd    = rd_s;
        raw_s.cls   = CLS_LOAD;
        raw_s.sel_b = SEL_IMM;
        illegal_s   = (f3_s[1:0] == 2'b11) || (f3_s == 3'b110);
      end
      OPC_STORE: begin
        raw_s.imm   = imm_s_s;
        raw_s.cls   = CLS_STORE;
        raw_s.sel_b = SEL_IMM;
        illegal_s   = f3_s[2] || (f3_s[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        raw_s.imm     = imm_i_s;
        raw_s.rd      = rd_s;
        raw_s.alu_fn  = f3_s;
        raw_s.alu_mod = (f3_s == 3'b101) && ins_s[30];
        raw_s.sel_b   = SEL_IMM;
      end
      OPC_OP: begin
        raw_s.rd     = rd_s;
        raw_s.alu_fn = f3_s;
        if (f7_s == 7'b0000000) begin
          raw_s.alu_mod = 1'b0;
        end else if ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))) begin
          raw_s.alu_mod = 1'b1;
        end else if ((f7_s == 7'b0000001) && ENABLE_M) begin
          raw_s.cls    = CLS_MULDIV;
          raw_s.alu_fn = ALU_ADD;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_FENCE: begin
        raw_s.cls = CLS_FENCE;
        illegal_s = (f3_s != 3'b000);
      end
      OPC_SYSTEM: begin
        case (f3_s)
          3'b000: begin
            // Privileged encodings must match every field exactly
            if (ins_s == 32'h0000_0073) begin
              raw_s.exception = 1'b1;
              raw_s.ecause    = 4'd11;
            end else if (ins_s == 32'h0010_0073) begin
              raw_s.exception = 1'b1;
              raw_s.ecause    = 4'd3;
            end else if (ins_s == 32'h3020_0073) begin
              raw_s.cls = CLS_MRET;
            end else if (ins_s == 32'h1050_0073) begin
              raw_s.cls = CLS_WFI;
            end else begin
              illegal_s = 1'b1;
            end
          end
          3'b100: illegal_s = 1'b1;
          default: begin
            raw_s.cls   = CLS_CSR;
            raw_s.rd    = rd_s;
            raw_s.sel_b = SEL_CSR;
            if (f3_s[2]) begin
              raw_s.imm   = {27'd0, rs1_s};
              raw_s.sel_a = SEL_IMM;
            end else begin
              raw_s.imm   = 32'd0;
              raw_s.sel_a = SEL_REG;
            end
            if (f3_s[1:0] == 2'b01) begin
              raw_s.csr_rd = (rd_s != 5'd0);
              raw_s.csr_wr = 1'b1;
              raw_s.alu_fn = ALU_OR;
            end else begin
              raw_s.csr_rd  = 1'b1;
              raw_s.csr_wr  = (rs1_s != 5'd0);
              raw_s.alu_fn  = (f3_s[1:0] == 2'b11) ? ALU_AND : ALU_OR;
              raw_s.alu_mod = (f3_s[1:0] == 2'b11);
            end
          end
        endcase
      end
      default: illegal_s = 1'b1;
    endcase

    if (illegal_s) begin
      uop_s           = '0;
      uop_s.pc        = raw_s.pc;
      uop_s.next_pc   = raw_s.next_pc;
      uop_s.rs1       = raw_s.rs1;
      uop_s.rs2       = raw_s.rs2;
      uop_s.csr_addr  = raw_s.csr_addr;
      uop_s.funct3    = raw_s.funct3;
      uop_s.exception = 1'b1;
      uop_s.ecause    = 4'd2;
    end else begin
      uop_s = raw_s;
    end
  end

  uop_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_s, out_valid_s, push_s, pop_s;
  uop_t          head_s;

  assign out_valid_s = (count_q != {CW{1'b0}});
  assign in_ready_s  = (count_q < CW'(DEPTH)) | dq.out_ready;
  assign push_s      = dq.in_valid & in_ready_s & ~dq.flush;
  assign pop_s       = out_valid_s & dq.out_ready;

  // Pointer and occupancy next-state; flush overrides any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (dq.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Queue control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Micro-op storage, written only on an accepted push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= uop_s;
    end
  end

  assign head_s          = mem_q[rd_ptr_q];
  assign dq.in_ready     = in_ready_s;
  assign dq.out_valid    = out_valid_s;
  assign dq.count        = count_q;
  assign dq.out_pc       = head_s.pc;
  assign dq.out_next_pc  = head_s.next_pc;
  assign dq.out_imm      = head_s.imm;
  assign dq.out_rs1      = head_s.rs1;
  assign dq.out_rs2      = head_s.rs2;
  assign dq.out_rd       = head_s.rd;
  assign dq.out_csr_addr = head_s.csr_addr;
  assign dq.out_alu_fn   = head_s.alu_fn;
  assign dq.out_alu_mod  = head_s.alu_mod;
  assign dq.out_sel_a    = head_s.sel_a;
  assign dq.out_sel_b    = head_s.sel_b;
  assign dq.out_funct3   = head_s.funct3;
  assign dq.out_class    = head_s.cls;
  assign dq.out_csr_rd   = head_s.csr_rd;
  assign dq.out_csr_wr   = head_s.csr_wr;
  assign dq.out_exception = head_s.exception;
  assign dq.out_ecause   = head_s.ecause;
endmodule
